// File: rtl/kbd_cmd_decoder.sv
// Keyboard command decoder. It captures one ASCII byte per rising edge of kbd_valid and matches it
// against a command table. Outputs are one-cycle pulses, a latched last command and a repeat hold-off.
module kbd_cmd_decoder #(
   parameter int unsigned           NUM_CMDS         = 5,
   parameter logic [8*NUM_CMDS-1:0] CMD_CHARS        = 40'h5246424544,
   parameter bit                    CASE_INSENSITIVE = 1'b1,
   parameter int unsigned           HOLDOFF_CYCLES   = 1000,
   parameter int unsigned           CNT_W            = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [7:0]          kbd_data,
   input  logic                kbd_valid,
   output logic [NUM_CMDS-1:0] cmd_pulse,
   output logic [NUM_CMDS-1:0] cmd_level,
   output logic                unknown_pulse,
   output logic [7:0]          last_char,
   output logic                holdoff_active
);

   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLDOFF_CYCLES);

   typedef enum logic {StReady = 1'b0, StHold = 1'b1} hold_state_e;

   hold_state_e         state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                v_q;
   logic                pend_q;
   logic [7:0]          last_char_q;
   logic [NUM_CMDS-1:0] cmd_pulse_q;
   logic [NUM_CMDS-1:0] cmd_level_q;
   logic                unknown_q;

   logic [7:0]          folded;
   logic                capture;
   logic                match_any;
   logic [NUM_CMDS-1:0] match_oh;
   logic                repeat_blocked;
   logic                accept;
   logic                unknown_d;

   always_comb begin
      folded = kbd_data;
      if (CASE_INSENSITIVE && kbd_data >= 8'h61 && kbd_data <= 8'h7A) begin
         folded = kbd_data - 8'h20;
      end
   end

   assign capture = kbd_valid & ~v_q;

   // Ascending scan with a found flag, so the lowest duplicated entry wins.
   always_comb begin
      match_any = 1'b0;
      match_oh  = '0;
      for (int i = 0; i < int'(NUM_CMDS); i++) begin
         if (!match_any && last_char_q == CMD_CHARS[8*i +: 8]) begin
            match_any   = 1'b1;
            match_oh[i] = 1'b1;
         end
      end
   end

   // cmd_level doubles as the one-hot last-accepted index; all-zero means none.
   assign repeat_blocked = (|(match_oh & cmd_level_q)) & (state_q == StHold);
   assign accept         = pend_q & match_any & ~repeat_blocked;
   assign unknown_d      = pend_q & ~match_any;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         v_q         <= 1'b0;
         pend_q      <= 1'b0;
         last_char_q <= 8'h00;
         cmd_pulse_q <= '0;
         cmd_level_q <= '0;
         unknown_q   <= 1'b0;
      end else begin
         v_q         <= kbd_valid;
         pend_q      <= capture;
         if (capture) begin
            last_char_q <= folded;
         end
         cmd_pulse_q <= accept ? match_oh : '0;
         if (accept) begin
            cmd_level_q <= match_oh;
         end
         unknown_q   <= unknown_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StReady;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StReady: begin
            if (accept && HOLDOFF_CYCLES != 0) begin
               state_d = StHold;
               cnt_d   = HOLD_LOAD;
            end
         end
         StHold: begin
            if (accept) begin
               cnt_d = HOLD_LOAD;
            end else if (cnt_q == CNT_W'(1)) begin
               cnt_d   = '0;
               state_d = StReady;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = StReady;
            cnt_d   = '0;
         end
      endcase
   end

   assign cmd_pulse      = cmd_pulse_q;
   assign cmd_level      = cmd_level_q;
   assign unknown_pulse  = unknown_q;
   assign last_char      = last_char_q;
   assign holdoff_active = (state_q == StHold);

endmodule
